// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: requester IDs and the
// ownership tag carried alongside each in-flight memory request.
package mem_port_arbiter_pkg;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mem_port_arbiter_tag_delay_line.sv
// Ownership tag delay line matching the memory pipeline depth, plus the
// generic enable/reset register cell it is built from.
module Nbit_reg #(
  parameter int             N           = 1,
  parameter logic [N-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VALUE;
    else if (we)
      q <= d;
  end

endmodule

module tag_delay_line
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [0:LATENCY];

  assign stage[0] = tag_in;

  // Each register advances only with gwe so tags stay aligned with memory.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    Nbit_reg #(.N(TAG_W)) u_reg (
      .clk (clk),
      .rst (rst),
      .we  (gwe),
      .d   (stage[k]),
      .q   (stage[k+1])
    );
  end

  assign tag_out = stage[LATENCY];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the I and
// D miss paths, with per-requester in-flight limits and response steering.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 8,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              gwe,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] cnt_i, cnt_d;
  logic             last_gnt;
  logic             active, elig_i, elig_d, grant, winner;
  tag_t             tag_in, tag_out;
  logic [TAG_W-1:0] tag_out_bits;

  // Saturating so a counter can never wrap even if inc/dec were misused.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
    if (inc && !dec && c != CNT_MAX)
      return c + CNT_W'(1);
    else if (dec && !inc && c != '0)
      return c - CNT_W'(1);
    else
      return c;
  endfunction

  always_comb begin
    active = gwe && !rst;
    elig_i = i_req && (cnt_i < CNT_MAX);
    elig_d = d_req && (cnt_d < CNT_MAX);
    grant  = active && (elig_i || elig_d);
    if (elig_i && elig_d)
      winner = ~last_gnt;
    else
      winner = elig_d ? REQ_D : REQ_I;
  end

  assign i_gnt         = grant && (winner == REQ_I);
  assign d_gnt         = grant && (winner == REQ_D);
  assign mem_req_valid = grant;
  assign mem_addr      = (winner == REQ_D) ? d_addr  : i_addr;
  assign mem_we        = grant && ((winner == REQ_D) ? d_we : i_we);
  assign mem_wdata     = (winner == REQ_D) ? d_wdata : i_wdata;

  assign tag_in.valid = grant;
  assign tag_in.owner = winner;

  tag_delay_line #(.LATENCY(LATENCY)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .gwe     (gwe),
    .tag_in  (tag_in),
    .tag_out (tag_out_bits)
  );

  assign tag_out     = tag_t'(tag_out_bits);
  assign i_rsp_valid = active && tag_out.valid && (tag_out.owner == REQ_I);
  assign d_rsp_valid = active && tag_out.valid && (tag_out.owner == REQ_D);
  assign i_rsp_data  = mem_rsp_data;
  assign d_rsp_data  = mem_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i    <= '0;
      cnt_d    <= '0;
      last_gnt <= REQ_D;
    end else if (gwe) begin
      cnt_i <= next_count(cnt_i, i_gnt, i_rsp_valid);
      cnt_d <= next_count(cnt_d, d_gnt, d_rsp_valid);
      if (grant)
        last_gnt <= winner;
    end
  end

endmodule
